fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 108 ++++++++++
 tb/tb_fetch_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
`timescale 1ns/1ps
// fetch_unit: single-entry instruction fetch stage feeding decode.
// Holds the PC, addresses a combinational instruction memory and registers
// the fetched word into a valid/ready output slot. Redirects override
// everything and flush the held instruction.
// Optional build macro: FETCH_MISALIGN_TRAP_EN -- misaligned redirect targets
// raise a sticky fetch_fault and halt fetch instead of being force-aligned.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [5:0]  imem_read_reg,
   input  logic [31:0] imem_read_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        id_ready,
   output logic        id_valid,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc,
   output logic        fetch_fault,
   output logic [31:0] fault_pc
);

   logic [31:0] pc_q, pc_d;
   logic        id_valid_q, id_valid_d;
   logic [31:0] id_instr_q, id_instr_d;
   logic [31:0] id_pc_q, id_pc_d;
   logic        fault_q;
   logic [31:0] fault_pc_q;
   logic [31:0] redirect_target;
   logic        advance;

`ifdef FETCH_MISALIGN_TRAP_EN
   logic        fault_d;
   logic [31:0] fault_pc_d;
   assign redirect_target = redirect_pc;
`else
   assign redirect_target = redirect_pc & ~32'h0000_0003;
   assign fault_q         = 1'b0;
   assign fault_pc_q      = '0;
`endif

   // Slot is free (empty or draining) and nothing overrides a sequential fetch
   assign advance = (!id_valid_q || id_ready) && !redirect_valid && !fault_q;

   // Next-state selection: redirect beats advance beats hold
   always_comb begin
      pc_d       = pc_q;
      id_valid_d = id_valid_q;
      id_instr_d = id_instr_q;
      id_pc_d    = id_pc_q;
`ifdef FETCH_MISALIGN_TRAP_EN
      fault_d    = fault_q;
      fault_pc_d = fault_pc_q;
`endif
      if (redirect_valid) begin
         // Any held instruction is either transferred this cycle or dropped;
         // either way the slot empties.
         pc_d       = redirect_target;
         id_valid_d = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
         if (redirect_pc[1:0] != 2'b00) begin
            fault_d    = 1'b1;
            fault_pc_d = redirect_pc;
         end else begin
            fault_d    = 1'b0;
         end
`endif
      end else if (advance) begin
         id_instr_d = imem_read_data;
         id_pc_d    = pc_q;
         id_valid_d = 1'b1;
         pc_d       = pc_q + 32'd4;
      end
   end

   // State registers with asynchronous reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q       <= RESET_PC;
         id_valid_q <= 1'b0;
         id_instr_q <= '0;
         id_pc_q    <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
         fault_q    <= 1'b0;
         fault_pc_q <= '0;
`endif
      end else begin
         pc_q       <= pc_d;
         id_valid_q <= id_valid_d;
         id_instr_q <= id_instr_d;
         id_pc_q    <= id_pc_d;
`ifdef FETCH_MISALIGN_TRAP_EN
         fault_q    <= fault_d;
         fault_pc_q <= fault_pc_d;
`endif
      end
   end

   assign imem_read_reg = pc_q[7:2];
   assign id_valid      = id_valid_q;
   assign id_instr      = id_instr_q;
   assign id_pc         = id_pc_q;
   assign fetch_fault   = fault_q;
   assign fault_pc      = fault_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
// tb_fetch_unit: scoreboard bench for fetch_unit. Each fetched instruction
// is predicted when the fetch is driven and compared when decode takes it.
module tb_fetch_unit;

   logic        clk;
   logic        rst_n;
   logic [5:0]  imem_read_reg;
   logic [31:0] imem_read_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        id_ready;
   logic        id_valid;
   logic [31:0] id_instr;
   logic [31:0] id_pc;
   logic        fetch_fault;
   logic [31:0] fault_pc;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   exp_t        sb_q[$];
   int unsigned checks   = 0;
   int unsigned failures = 0;

   // Bench-side reference state
   logic [31:0] m_pc;
   logic        m_valid;
   logic        m_fault;
   logic [31:0] m_fpc;

   fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .imem_read_reg (imem_read_reg),
      .imem_read_data(imem_read_data),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc),
      .id_ready      (id_ready),
      .id_valid      (id_valid),
      .id_instr      (id_instr),
      .id_pc         (id_pc),
      .fetch_fault   (fetch_fault),
      .fault_pc      (fault_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [5:0] a);
      mem_word = 32'hC0DE_0000 ^ ({26'd0, a} * 32'h0001_0203);
   endfunction

   assign imem_read_data = mem_word(imem_read_reg);

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic model_reset();
      m_pc    = 32'h0;
      m_valid = 1'b0;
      m_fault = 1'b0;
      m_fpc   = 32'h0;
      sb_q.delete();
   endtask

   // One cycle: called at a negedge, drives inputs, checks outputs against the
   // model, predicts the next state, and returns at the following negedge.
   task automatic step(input logic rdy, input logic rv, input logic [31:0] rpc);
      exp_t e;
      logic adv;
      id_ready       = rdy;
      redirect_valid = rv;
      redirect_pc    = rpc;
      #1;
      check_eq("imem_read_reg", {26'd0, imem_read_reg}, {26'd0, m_pc[7:2]});
      check_eq("id_valid", {31'd0, id_valid}, {31'd0, m_valid});
      check_eq("fetch_fault", {31'd0, fetch_fault}, {31'd0, m_fault});
      check_eq("fault_pc", fault_pc, m_fpc);
      if (m_valid) begin
         if (sb_q.size() == 0) begin
            check_eq("sb_empty", 32'd0, 32'd1);
         end else begin
            e = sb_q[0];
            check_eq("id_pc", id_pc, e.pc);
            check_eq("id_instr", id_instr, e.instr);
            // taken by decode, or flushed by the redirect
            if (rdy || rv) void'(sb_q.pop_front());
         end
      end
      adv = (!m_valid || rdy) && !rv && !m_fault;
      if (rv) begin
         m_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
         m_pc = rpc;
         if (rpc[1:0] != 2'b00) begin
            m_fault = 1'b1;
            m_fpc   = rpc;
         end else begin
            m_fault = 1'b0;
         end
`else
         m_pc = {rpc[31:2], 2'b00};
`endif
      end else if (adv) begin
         e.pc    = m_pc;
         e.instr = mem_word(m_pc[7:2]);
         sb_q.push_back(e);
         m_valid = 1'b1;
         m_pc    = m_pc + 32'd4;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst_n          = 1'b0;
      id_ready       = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      check_eq("rst_id_valid", {31'd0, id_valid}, 32'd0);
      check_eq("rst_imem_read_reg", {26'd0, imem_read_reg}, 32'd0);
      check_eq("rst_id_pc", id_pc, 32'd0);
      check_eq("rst_id_instr", id_instr, 32'd0);
      check_eq("rst_fetch_fault", {31'd0, fetch_fault}, 32'd0);
      rst_n = 1'b1;

      // Streaming fetch from reset, then a 3-cycle stall at id_pc 0x8
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0);
      check_eq("stream_id_pc8", id_pc, 32'h8);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 32'h0);
         check_eq("stall_id_pc", id_pc, 32'h8);
         check_eq("stall_imem", {26'd0, imem_read_reg}, 32'd3);
      end
      step(1'b1, 1'b0, 32'h0);
      check_eq("resume_id_pc", id_pc, 32'hC);
      step(1'b0, 1'b0, 32'h0);
      // Redirect during stall
      step(1'b0, 1'b1, 32'h40);
      check_eq("redir_valid0", {31'd0, id_valid}, 32'd0);
      check_eq("redir_imem16", {26'd0, imem_read_reg}, 32'd16);
      step(1'b1, 1'b0, 32'h0);
      check_eq("redir_id_pc", id_pc, 32'h40);
      step(1'b1, 1'b0, 32'h0);

      // Wrap of the 6-bit word address across 0xFC -> 0x100
      step(1'b1, 1'b1, 32'hF8);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h0);

      // Random ready and occasional aligned redirects
      for (int i = 0; i < 60; i++) begin
         logic rv;
         rv = ($urandom_range(0, 7) == 0);
         step(logic'($urandom_range(0, 1)), rv, $urandom & 32'h0000_01FC);
      end

      // Misaligned redirect: trap in one build, forced alignment in the other
      step(1'b1, 1'b1, 32'h42);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
      check_eq("trap_fault", {31'd0, fetch_fault}, 32'd1);
      check_eq("trap_fault_pc", fault_pc, 32'h42);
      check_eq("trap_valid0", {31'd0, id_valid}, 32'd0);
      step(1'b1, 1'b1, 32'h10);
      check_eq("trap_cleared", {31'd0, fetch_fault}, 32'd0);
      step(1'b1, 1'b0, 32'h0);
      check_eq("trap_resume_pc", id_pc, 32'h10);
`else
      check_eq("align_fetch_pc", id_pc, 32'h48);
      check_eq("align_fault0", {31'd0, fetch_fault}, 32'd0);
`endif
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0);

      // Asynchronous reset mid-stream around pc 0x20
      step(1'b1, 1'b1, 32'h18);
      step(1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b0, 32'h0);
      check_eq("pre_rst_imem", {26'd0, imem_read_reg}, 32'd8);
      #2 rst_n = 1'b0;
      #1;
      check_eq("async_rst_valid", {31'd0, id_valid}, 32'd0);
      check_eq("async_rst_imem", {26'd0, imem_read_reg}, 32'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0);
      check_eq("post_rst_id_pc", id_pc, 32'hC);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Overall time bound so the run always terminates
   initial begin
      #200000;
      $display("FAIL timeout: got 0 expected 1");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

endmodule
